rvv_lsu_uop_splitter: RTL and testbench
=======================================

RVV_LSU_UOP_SPLITTER -- requirements
Module: rvv_lsu_uop_splitter

Interface
- REQ-001: Parameter NUM_OUT, default 2, maximum uops emitted per cycle; legal range 1..4.
- REQ-002: Parameter UOP_INDEX_WIDTH, default 3, uop index width; 8 uops maximum per instruction.
- REQ-003: Clock and reset SHALL be one clock and an asynchronous, active-low reset: clk and rst_n.
- REQ-004: clk  in  1  clock.
- REQ-005: rst_n  in  1  asynchronous active-low reset.
- REQ-006: inst_valid  in  1; inst_ready  out  1  instruction handshake; transfer when both are 1 at a rising edge.
- REQ-007: inst_pc  in  32  PC of the instruction.
- REQ-008: inst_mop  in  2  access mode: 00 unit-stride, 01 indexed-unordered, 10 strided, 11 indexed-ordered.
- REQ-009: inst_width  in  3  EEW encoding: 000=8, 101=16, 110=32; other values reserved.
- REQ-010: inst_vd, inst_vs2  in  5 each  base registers.
- REQ-011: vill  in  1; vsew  in  3; vlmul  in  3  vtype fields with the standard RVV encodings.
- REQ-012: uop_valid  out  NUM_OUT  per-slot valid, contiguous from slot 0.
- REQ-013: uop_ready  in  1  consumer accepts all valid slots in the current cycle.
- REQ-014: uop_index  out  NUM_OUT*UOP_INDEX_WIDTH  per-slot uop index.
- REQ-015: uop_vd, uop_vs2  out  NUM_OUT*5 each  per-slot register numbers.
- REQ-016: uop_pc  out  32  PC of the instruction being split.
- REQ-017: uop_last  out  NUM_OUT  marks the final uop of the instruction.
- REQ-018: uop_illegal  out  1  the current instruction is illegal.

Function
- REQ-019: The FSM SHALL have two states, IDLE and SPLIT; reset state is IDLE.
- REQ-020: inst_ready SHALL be 1 in IDLE, and in SPLIT only when the remaining uop count is <= NUM_OUT and uop_ready=1. This permits back-to-back instructions with no bubble.
- REQ-021: On accept, all instruction fields SHALL be registered, the next uop index set to 0, and the state set to SPLIT. Outputs appear the cycle after accept.
- REQ-022: Unit-stride and strided: EMUL_d = EEW/SEW*LMUL; uop count = max(1, EMUL_d).
- REQ-023: Indexed: EMUL_d = LMUL; EMUL_i = EEW/SEW*LMUL; uop count = max(1, EMUL_d, EMUL_i).
- REQ-024: The instruction SHALL be illegal if vill=1, inst_width is reserved, vsew/vlmul is reserved, or any EMUL is > 8 or < 1/8.
- REQ-025: An illegal instruction SHALL emit exactly one uop: index 0, uop_illegal=1, uop_last=1.
- REQ-026: Each SPLIT cycle SHALL present k = min(NUM_OUT, remaining) valid slots. Slot j carries index = next + j and uop_last=1 only on index count-1.
- REQ-027: uop_vd = inst_vd + (index >> log2(count/max(1,EMUL_d))).
- REQ-028: uop_vs2 = inst_vs2 + (index >> log2(count/max(1,EMUL_reg))), where EMUL_reg is EMUL_i if indexed, else 0. Strided and unit-stride hold uop_vs2 = inst_vs2.
- REQ-029: Register-number addition SHALL wrap modulo 32.
- REQ-030: While uop_ready=0, all uop outputs SHALL hold stable.
- REQ-031: With uop_ready=1, next SHALL advance by k.
- REQ-032: When the last uop is accepted, go to IDLE, or stay in SPLIT if a new instruction is accepted in the same cycle.
- REQ-033: uop_valid SHALL be all-zero in IDLE.

Reset
- REQ-034: Asynchronous assertion SHALL force IDLE and set uop_valid=0, uop_last=0, uop_illegal=0, index counter=0, uop_pc=0, uop_vd=0, and uop_vs2=0.
- REQ-035: Reset asserted mid-split SHALL discard the instruction; no residual uops are emitted after reset deasserts.
- REQ-036: inst_ready SHALL be 1 on the first cycle after reset deasserts.

Verification
- REQ-037: Unit-stride, width=110, vsew=000, vlmul=000 (EMUL=4), vd=8, NUM_OUT=2, uop_ready=1 -> cycle 1 indices 0,1 (vd 8,9); cycle 2 indices 2,3 (vd 10,11), slot 1 uop_last=1.
- REQ-038: Indexed, vsew=010, vlmul=001 (EMUL_d=2), width=000 (EMUL_i=1/2), vd=4, vs2=2 -> 2 uops: vd 4,5; vs2 2,2.
- REQ-039: Illegal case: width=110, vsew=000, vlmul=011 (EMUL=32) -> one uop with uop_illegal=1 and uop_last=1. vill=1 with any fields -> same response.
- REQ-040: EMUL=8 instruction with uop_ready toggling 1,0,1,0 -> outputs hold during stalls; all 8 indices appear exactly once, in order; back-to-back second instruction starts with no bubble.
- REQ-041: rst_n pulsed low after 2 of 8 uops -> uop_valid=0 immediately and inst_ready=1 after release; a new EMUL=1 instruction then emits only index 0.
- REQ-042: vd=30 with EMUL=4 -> uop_vd sequence 30,31,0,1.

Source files
------------

// File: rtl/rvv_lsu_uop_splitter.sv
// RVV load/store micro-op splitter: decodes EEW/SEW/LMUL into a uop count and
// emits up to NUM_OUT uops per cycle with per-uop register offsets.
module rvv_lsu_uop_splitter #(
  parameter int unsigned NUM_OUT         = 2,
  parameter int unsigned UOP_INDEX_WIDTH = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 inst_valid,
  output logic                                 inst_ready,
  input  logic [31:0]                          inst_pc,
  input  logic [1:0]                           inst_mop,
  input  logic [2:0]                           inst_width,
  input  logic [4:0]                           inst_vd,
  input  logic [4:0]                           inst_vs2,
  input  logic                                 vill,
  input  logic [2:0]                           vsew,
  input  logic [2:0]                           vlmul,
  output logic [NUM_OUT-1:0]                   uop_valid,
  input  logic                                 uop_ready,
  output logic [NUM_OUT*UOP_INDEX_WIDTH-1:0]   uop_index,
  output logic [NUM_OUT*5-1:0]                 uop_vd,
  output logic [NUM_OUT*5-1:0]                 uop_vs2,
  output logic [31:0]                          uop_pc,
  output logic [NUM_OUT-1:0]                   uop_last,
  output logic                                 uop_illegal
);

  localparam int unsigned CW = UOP_INDEX_WIDTH + 1;
  localparam logic [CW-1:0] NUM_OUT_C = CW'(NUM_OUT);

  typedef enum logic {IDLE, SPLIT} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [4:0]    vd_q, vd_d, vs2_q, vs2_d;
  logic [CW-1:0] next_q, next_d;
  logic [3:0]    cnt_log_q, cnt_log_d, vd_shift_q, vd_shift_d, vs2_shift_q, vs2_shift_d;
  logic          illegal_q, illegal_d;

  logic signed [3:0] eew_log, sew_log, lmul_log, emul_i, emul_d, emul_d_pos, emul_r_pos, cnt_s;
  logic              dec_bad, dec_illegal;
  logic [3:0]        dec_cnt_log, dec_vd_shift, dec_vs2_shift;
  logic [CW-1:0]     count, remaining;
  logic              last_batch;
  logic              unused_mop;

  // strided and unit-stride split identically
  assign unused_mop = inst_mop[1];

  // All quantities are log2 values; vlmul sign-extends directly to log2(LMUL).
  always_comb begin
    dec_bad  = 1'b0;
    eew_log  = '0;
    sew_log  = '0;
    lmul_log = '0;
    case (inst_width)
      3'b000:  eew_log = 4'sd0;
      3'b101:  eew_log = 4'sd1;
      3'b110:  eew_log = 4'sd2;
      default: dec_bad = 1'b1;
    endcase
    if (vsew[2]) dec_bad = 1'b1;
    else         sew_log = {2'b00, vsew[1:0]};
    if (vlmul == 3'b100) dec_bad = 1'b1;
    else                 lmul_log = {vlmul[2], vlmul};
    emul_i = eew_log - sew_log + lmul_log;
    emul_d = inst_mop[0] ? lmul_log : emul_i;
    dec_illegal = vill || dec_bad || (emul_d > 4'sd3) || (emul_d < -4'sd3) ||
                  (inst_mop[0] && ((emul_i > 4'sd3) || (emul_i < -4'sd3)));
    emul_d_pos = (emul_d > 4'sd0) ? emul_d : 4'sd0;
    emul_r_pos = (inst_mop[0] && (emul_i > 4'sd0)) ? emul_i : 4'sd0;
    cnt_s      = (emul_r_pos > emul_d_pos) ? emul_r_pos : emul_d_pos;
    if (dec_illegal) begin
      dec_cnt_log   = '0;
      dec_vd_shift  = '0;
      dec_vs2_shift = '0;
    end else begin
      dec_cnt_log   = $unsigned(cnt_s);
      dec_vd_shift  = $unsigned(cnt_s - emul_d_pos);
      dec_vs2_shift = $unsigned(cnt_s - emul_r_pos);
    end
  end

  assign count      = CW'(1) << cnt_log_q;
  assign remaining  = count - next_q;
  assign last_batch = (remaining <= NUM_OUT_C);
  assign inst_ready = (state_q == IDLE) || (last_batch && uop_ready);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    vd_d        = vd_q;
    vs2_d       = vs2_q;
    next_d      = next_q;
    cnt_log_d   = cnt_log_q;
    vd_shift_d  = vd_shift_q;
    vs2_shift_d = vs2_shift_q;
    illegal_d   = illegal_q;
    if (state_q == SPLIT && uop_ready) begin
      if (last_batch) state_d = IDLE;
      else            next_d  = next_q + NUM_OUT_C;
    end
    if (inst_valid && inst_ready) begin
      state_d     = SPLIT;
      pc_d        = inst_pc;
      vd_d        = inst_vd;
      vs2_d       = inst_vs2;
      next_d      = '0;
      cnt_log_d   = dec_cnt_log;
      vd_shift_d  = dec_vd_shift;
      vs2_shift_d = dec_vs2_shift;
      illegal_d   = dec_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      vd_q        <= '0;
      vs2_q       <= '0;
      next_q      <= '0;
      cnt_log_q   <= '0;
      vd_shift_q  <= '0;
      vs2_shift_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      vd_q        <= vd_d;
      vs2_q       <= vs2_d;
      next_q      <= next_d;
      cnt_log_q   <= cnt_log_d;
      vd_shift_q  <= vd_shift_d;
      vs2_shift_q <= vs2_shift_d;
      illegal_q   <= illegal_d;
    end
  end

  // Slot fields are zeroed when the slot is not valid so reset/idle outputs read 0.
  always_comb begin
    logic [CW-1:0] idx;
    logic          v;
    uop_valid   = '0;
    uop_index   = '0;
    uop_vd      = '0;
    uop_vs2     = '0;
    uop_last    = '0;
    uop_pc      = pc_q;
    uop_illegal = (state_q == SPLIT) && illegal_q;
    for (int unsigned j = 0; j < NUM_OUT; j++) begin
      idx = next_q + CW'(j);
      v   = (state_q == SPLIT) && (CW'(j) < remaining);
      uop_valid[j] = v;
      if (v) begin
        uop_index[j*UOP_INDEX_WIDTH +: UOP_INDEX_WIDTH] = idx[UOP_INDEX_WIDTH-1:0];
        uop_vd[j*5 +: 5]  = vd_q + 5'(idx >> vd_shift_q);
        uop_vs2[j*5 +: 5] = vs2_q + 5'(idx >> vs2_shift_q);
        uop_last[j]       = (idx == count - CW'(1));
      end
    end
  end

endmodule

// File: tb/tb_rvv_lsu_uop_splitter.sv
// Bench for rvv_lsu_uop_splitter: directed and random instructions checked
// against a fraction-arithmetic model of the expected uop stream.
module tb_rvv_lsu_uop_splitter;

  localparam int N = 2;
  localparam int W = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inst_valid, inst_ready;
  logic [31:0]   inst_pc;
  logic [1:0]    inst_mop;
  logic [2:0]    inst_width;
  logic [4:0]    inst_vd, inst_vs2;
  logic          vill;
  logic [2:0]    vsew, vlmul;
  logic [N-1:0]  uop_valid;
  logic          uop_ready;
  logic [N*W-1:0] uop_index;
  logic [N*5-1:0] uop_vd, uop_vs2;
  logic [31:0]   uop_pc;
  logic [N-1:0]  uop_last;
  logic          uop_illegal;

  rvv_lsu_uop_splitter #(.NUM_OUT(N), .UOP_INDEX_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_pc(inst_pc), .inst_mop(inst_mop), .inst_width(inst_width),
    .inst_vd(inst_vd), .inst_vs2(inst_vs2),
    .vill(vill), .vsew(vsew), .vlmul(vlmul),
    .uop_valid(uop_valid), .uop_ready(uop_ready),
    .uop_index(uop_index), .uop_vd(uop_vd), .uop_vs2(uop_vs2),
    .uop_pc(uop_pc), .uop_last(uop_last), .uop_illegal(uop_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    int          vd;
    int          vs2;
    bit          last;
    bit          ill;
    logic [31:0] pc;
  } uop_t;

  uop_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_inst(input logic [1:0] mop, input logic [2:0] w, input logic [2:0] sew,
                          input logic [2:0] lmul, input logic [4:0] vd, input logic [4:0] vs2,
                          input logic vi);
    inst_pc    = $urandom;
    inst_mop   = mop;
    inst_width = w;
    vsew       = sew;
    vlmul      = lmul;
    inst_vd    = vd;
    inst_vs2   = vs2;
    vill       = vi;
  endtask

  // EMULs are tracked as multiples of 1/8 so fractional LMUL stays integral.
  task automatic push_inst();
    int eew, sew, lmul8, emuli8, emuld8, cnt8, count, vd_grp, vs2_grp, ri;
    bit ill, indexed;
    uop_t u;
    eew = (inst_width == 3'd0) ? 8 : (inst_width == 3'd5) ? 16 : (inst_width == 3'd6) ? 32 : 0;
    sew = (vsew < 3'd4) ? (8 << vsew) : 0;
    case (vlmul)
      3'd0: lmul8 = 8;  3'd1: lmul8 = 16; 3'd2: lmul8 = 32; 3'd3: lmul8 = 64;
      3'd5: lmul8 = 1;  3'd6: lmul8 = 2;  3'd7: lmul8 = 4;  default: lmul8 = 0;
    endcase
    indexed = inst_mop[0];
    ill = vill || eew == 0 || sew == 0 || lmul8 == 0;
    emuli8 = 0;
    emuld8 = 0;
    if (!ill) begin
      emuli8 = eew * lmul8 / sew;
      emuld8 = indexed ? lmul8 : emuli8;
      if (emuld8 < 1 || emuld8 > 64) ill = 1;
      if (indexed && (emuli8 < 1 || emuli8 > 64)) ill = 1;
    end
    u.pc = inst_pc;
    if (ill) begin
      u.idx = 0; u.vd = inst_vd; u.vs2 = inst_vs2; u.last = 1; u.ill = 1;
      q.push_back(u);
      return;
    end
    ri = indexed ? emuli8 : 0;
    cnt8 = 8;
    if (emuld8 > cnt8) cnt8 = emuld8;
    if (ri > cnt8) cnt8 = ri;
    count   = cnt8 / 8;
    vd_grp  = cnt8 / ((emuld8 > 8) ? emuld8 : 8);
    vs2_grp = cnt8 / ((ri > 8) ? ri : 8);
    for (int i = 0; i < count; i++) begin
      u.idx  = i;
      u.vd   = (inst_vd + i / vd_grp) % 32;
      u.vs2  = (inst_vs2 + i / vs2_grp) % 32;
      u.last = (i == count - 1);
      u.ill  = 0;
      q.push_back(u);
    end
  endtask

  // Called at a falling edge; drives inputs, checks outputs, advances the model.
  task automatic step(input bit rdy, input bit send);
    int k;
    bit exp_rdy;
    uop_ready  = rdy;
    inst_valid = send;
    #1;
    k = (q.size() < N) ? q.size() : N;
    exp_rdy = (q.size() == 0) || (q.size() <= N && rdy);
    chk("inst_ready", 64'(inst_ready), 64'(exp_rdy));
    chk("uop_valid", 64'(uop_valid), 64'((1 << k) - 1));
    for (int j = 0; j < k; j++) begin
      chk($sformatf("index[%0d]", j), 64'(uop_index[j*W +: W]), 64'(q[j].idx));
      chk($sformatf("vd[%0d]", j),    64'(uop_vd[j*5 +: 5]),     64'(q[j].vd));
      chk($sformatf("vs2[%0d]", j),   64'(uop_vs2[j*5 +: 5]),    64'(q[j].vs2));
      chk($sformatf("last[%0d]", j),  64'(uop_last[j]),          64'(q[j].last));
    end
    if (k > 0) begin
      chk("uop_pc", 64'(uop_pc), 64'(q[0].pc));
      chk("uop_illegal", 64'(uop_illegal), 64'(q[0].ill));
    end
    if (rdy) for (int j = 0; j < k; j++) void'(q.pop_front());
    if (send && exp_rdy) push_inst();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"},   64'(uop_valid),   64'(0));
    chk({tag, "_last"},    64'(uop_last),    64'(0));
    chk({tag, "_illegal"}, 64'(uop_illegal), 64'(0));
    chk({tag, "_pc"},      64'(uop_pc),      64'(0));
    chk({tag, "_vd"},      64'(uop_vd),      64'(0));
    chk({tag, "_vs2"},     64'(uop_vs2),     64'(0));
    chk({tag, "_index"},   64'(uop_index),   64'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    uop_ready = 1'b0;
    inst_valid = 1'b0;
    set_inst(2'b00, 3'd0, 3'd0, 3'd0, 5'd0, 5'd0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    reset_checks("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Unit-stride EMUL=4 from vd=8
    set_inst(2'b00, 3'b110, 3'b000, 3'b000, 5'd8, 5'd3, 1'b0);
    step(1, 1);
    repeat (3) step(1, 0);

    // Indexed: EMUL_d=2, EMUL_i=1/2
    set_inst(2'b01, 3'b000, 3'b010, 3'b001, 5'd4, 5'd2, 1'b0);
    step(1, 1);
    repeat (2) step(1, 0);

    // Illegal EMUL=32, then vill
    set_inst(2'b00, 3'b110, 3'b000, 3'b011, 5'd7, 5'd9, 1'b0);
    step(1, 1);
    step(1, 0);
    set_inst(2'b10, 3'b000, 3'b000, 3'b000, 5'd1, 5'd1, 1'b1);
    step(1, 1);
    step(1, 0);

    // EMUL=8 with stalls, second instruction queued back-to-back
    set_inst(2'b00, 3'b110, 3'b000, 3'b001, 5'd16, 5'd0, 1'b0);
    step(1, 1);
    set_inst(2'b00, 3'b101, 3'b000, 3'b000, 5'd20, 5'd0, 1'b0);
    for (int i = 0; i < 9; i++) step((i % 2) == 0, 1);
    inst_valid = 1'b0;
    repeat (4) step(1, 0);

    // vd wraps modulo 32
    set_inst(2'b10, 3'b110, 3'b000, 3'b000, 5'd30, 5'd5, 1'b0);
    step(1, 1);
    repeat (3) step(1, 0);

    // Reset in the middle of an 8-uop split
    set_inst(2'b00, 3'b110, 3'b000, 3'b001, 5'd0, 5'd0, 1'b0);
    step(1, 1);
    step(1, 0);
    rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_inst(2'b00, 3'b000, 3'b000, 3'b000, 5'd12, 5'd0, 1'b0);
    step(1, 1);
    repeat (3) step(1, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      int wr;
      logic [2:0] w;
      wr = $urandom_range(0, 3);
      w = (wr == 0) ? 3'd0 : (wr == 1) ? 3'd5 : (wr == 2) ? 3'd6 : 3'($urandom_range(0, 7));
      set_inst(2'($urandom_range(0, 3)), w, 3'($urandom_range(0, 4)), 3'($urandom_range(0, 7)),
               5'($urandom), 5'($urandom), $urandom_range(0, 15) == 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end
    repeat (6) step(1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
